// File: rtl/mem_responder_pkg.sv
// Shared definitions for the noun-memory responder: request encodings, widths,
// word field ranges and error flag indices.
package mem_responder_pkg;

   // Memory geometry.
   localparam int unsigned MEM_ADDR_W = 10;
   localparam int unsigned MEM_DATA_W = 64;

   // Reserved null address: never written, never allocated.
   localparam int unsigned MEM_NIL_ADDR = 1023;

   // Noun word layout: tag | hed | tel.
   localparam int unsigned TAG_MSB = 63;
   localparam int unsigned TAG_LSB = 60;
   localparam int unsigned HED_MSB = 59;
   localparam int unsigned HED_LSB = 30;
   localparam int unsigned TEL_MSB = 29;
   localparam int unsigned TEL_LSB = 0;

   // mem_func encodings.
   localparam logic [1:0] FUNC_GET_CONTENTS = 2'b00;
   localparam logic [1:0] FUNC_SET_CONTENTS = 2'b01;
   localparam logic [1:0] FUNC_GET_FREE     = 2'b10;
   localparam logic [1:0] FUNC_GET_PAIR     = 2'b11;

   // Sticky error flag positions.
   localparam int unsigned ERR_OOM       = 0;
   localparam int unsigned ERR_NIL_WRITE = 1;

endpackage

// File: rtl/mem_responder_ram_2r1w.sv
// Inferred RAM: two synchronous read ports, one write port.
// Read-during-write to the same address returns the old word.
module mem_responder_ram_2r1w #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 64
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr1_i,
   input  logic [ADDR_W-1:0] raddr2_i,
   output logic [DATA_W-1:0] rdata1_o,
   output logic [DATA_W-1:0] rdata2_o
);

   localparam int unsigned Depth = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [Depth];
   logic [DATA_W-1:0] rdata1_q;
   logic [DATA_W-1:0] rdata2_q;

   // Write port.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Both read ports register their word one cycle after the address.
   always_ff @(posedge clk_i) begin
      rdata1_q <= mem_q[raddr1_i];
      rdata2_q <= mem_q[raddr2_i];
   end

   assign rdata1_o = rdata1_q;
   assign rdata2_o = rdata2_q;

endmodule

// File: rtl/mem_responder.sv
// Noun-memory responder: serves get/set/pair requests against the noun store
// and runs a bump allocator for fresh cells.
// Optional: define MEM_SCRUB_ON_ALLOC_EN to zero each freshly allocated cell
// (adds one cycle to GET_FREE).
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int unsigned ADDR_W    = MEM_ADDR_W,
   parameter int unsigned DATA_W    = MEM_DATA_W,
   parameter int unsigned FREE_BASE = 512,
   parameter int unsigned NIL_ADDR  = MEM_NIL_ADDR
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_execute,
   input  logic [1:0]        mem_func,
   input  logic [ADDR_W-1:0] address1,
   input  logic [ADDR_W-1:0] address2,
   input  logic [DATA_W-1:0] write_data,
   output logic              mem_ready,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   output logic [ADDR_W-1:0] free_addr,
   output logic [7:0]        error
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;
`ifdef MEM_SCRUB_ON_ALLOC_EN
   localparam logic [1:0] ST_SCRUB  = 2'd3;
`endif

   localparam logic [ADDR_W-1:0] Nil      = ADDR_W'(NIL_ADDR);
   localparam logic [ADDR_W-1:0] FreeBase = ADDR_W'(FREE_BASE);

   logic [1:0]        state_q, state_d;
   logic [1:0]        func_q, func_d;
   logic [ADDR_W-1:0] addr1_q, addr1_d;
   logic [ADDR_W-1:0] addr2_q, addr2_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [ADDR_W-1:0] alloc_q, alloc_d;
   logic [ADDR_W-1:0] free_q, free_d;
   logic [1:0]        err_q, err_d;
   logic [DATA_W-1:0] rd1_q, rd1_d;
   logic [DATA_W-1:0] rd2_q, rd2_d;

   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata1;
   logic [DATA_W-1:0] ram_rdata2;
   logic [DATA_W-1:0] resp1;
   logic [DATA_W-1:0] resp2;

   mem_responder_ram_2r1w #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk_i    (clk),
      .we_i     (ram_we),
      .waddr_i  (ram_waddr),
      .wdata_i  (ram_wdata),
      .raddr1_i (addr1_q),
      .raddr2_i (addr2_q),
      .rdata1_o (ram_rdata1),
      .rdata2_o (ram_rdata2)
   );

   // Response words; reads of the null cell return zero since it is never written.
   always_comb begin
      resp1 = rd1_q;
      resp2 = rd2_q;
      case (func_q)
         FUNC_GET_CONTENTS: resp1 = (addr1_q == Nil) ? '0 : ram_rdata1;
         FUNC_SET_CONTENTS: resp1 = wdata_q;
         FUNC_GET_FREE:     resp1 = DATA_W'(alloc_q);
         default: begin
            resp1 = (addr1_q == Nil) ? '0 : ram_rdata1;
            resp2 = (addr2_q == Nil) ? '0 : ram_rdata2;
         end
      endcase
   end

   // Request FSM, allocator and RAM write control.
   always_comb begin
      state_d   = state_q;
      func_d    = func_q;
      addr1_d   = addr1_q;
      addr2_d   = addr2_q;
      wdata_d   = wdata_q;
      alloc_d   = alloc_q;
      free_d    = free_q;
      err_d     = err_q;
      rd1_d     = rd1_q;
      rd2_d     = rd2_q;
      ram_we    = 1'b0;
      ram_waddr = addr1_q;
      ram_wdata = wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (mem_execute) begin
               func_d  = mem_func;
               addr1_d = address1;
               addr2_d = address2;
               wdata_d = write_data;
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            state_d = ST_RESP;
            if (func_q == FUNC_SET_CONTENTS) begin
               if (addr1_q == Nil) begin
                  err_d[ERR_NIL_WRITE] = 1'b1;
               end else begin
                  ram_we = 1'b1;
               end
            end else if (func_q == FUNC_GET_FREE) begin
               if (free_q == Nil) begin
                  alloc_d         = Nil;
                  err_d[ERR_OOM]  = 1'b1;
               end else begin
                  alloc_d = free_q;
                  free_d  = free_q + ADDR_W'(1);
`ifdef MEM_SCRUB_ON_ALLOC_EN
                  state_d = ST_SCRUB;
`endif
               end
            end
         end
`ifdef MEM_SCRUB_ON_ALLOC_EN
         ST_SCRUB: begin
            ram_we    = 1'b1;
            ram_waddr = alloc_q;
            ram_wdata = '0;
            state_d   = ST_RESP;
         end
`endif
         ST_RESP: begin
            rd1_d   = resp1;
            rd2_d   = resp2;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // A reset landing on the commit cycle drops the write.
      if (rst) begin
         ram_we = 1'b0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         func_q  <= FUNC_GET_CONTENTS;
         addr1_q <= '0;
         addr2_q <= '0;
         wdata_q <= '0;
         alloc_q <= '0;
         free_q  <= FreeBase;
         err_q   <= '0;
         rd1_q   <= '0;
         rd2_q   <= '0;
      end else begin
         state_q <= state_d;
         func_q  <= func_d;
         addr1_q <= addr1_d;
         addr2_q <= addr2_d;
         wdata_q <= wdata_d;
         alloc_q <= alloc_d;
         free_q  <= free_d;
         err_q   <= err_d;
         rd1_q   <= rd1_d;
         rd2_q   <= rd2_d;
      end
   end

   assign mem_ready  = (state_q == ST_RESP);
   assign read_data1 = mem_ready ? resp1 : rd1_q;
   assign read_data2 = mem_ready ? resp2 : rd2_q;
   assign free_addr  = free_q;
   assign error      = {6'b0, err_q};

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: the driver pushes expected responses,
// a negedge monitor pops and checks data and latency on every mem_ready.
module tb_mem_responder;

   localparam logic [1:0] F_GET  = 2'b00;
   localparam logic [1:0] F_SET  = 2'b01;
   localparam logic [1:0] F_FREE = 2'b10;
   localparam logic [1:0] F_PAIR = 2'b11;

`ifdef MEM_SCRUB_ON_ALLOC_EN
   localparam int FreeLat = 3;
   localparam logic [63:0] Exp512 = 64'h0;
`else
   localparam int FreeLat = 2;
   localparam logic [63:0] Exp512 = 64'hFF;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_execute = 1'b0;
   logic [1:0]  mem_func = 2'b00;
   logic [9:0]  address1 = '0;
   logic [9:0]  address2 = '0;
   logic [63:0] write_data = '0;
   logic        mem_ready;
   logic [63:0] read_data1;
   logic [63:0] read_data2;
   logic [9:0]  free_addr;
   logic [7:0]  error;

   mem_responder dut (
      .clk        (clk),
      .rst        (rst),
      .mem_execute(mem_execute),
      .mem_func   (mem_func),
      .address1   (address1),
      .address2   (address2),
      .write_data (write_data),
      .mem_ready  (mem_ready),
      .read_data1 (read_data1),
      .read_data2 (read_data2),
      .free_addr  (free_addr),
      .error      (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] rd1;
      logic [63:0] rd2;
      int          due;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_tests = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic [63:0] m_rd2 = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every mem_ready must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (mem_ready === 1'b1) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_ready: mem_ready=1 at cycle %0d, required 0", cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("read_data1", read_data1, mon_e.rd1);
            chk("read_data2", read_data2, mon_e.rd2);
            chk("latency_cycle", 64'(cyc), 64'(mon_e.due));
         end
      end
   end

   task automatic wait_done();
      int k = 0;
      while (sb.size() != 0 && k < 10) begin
         @(negedge clk);
         k++;
      end
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL ready_timeout: got %0d pending responses, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic issue(input logic [1:0] f, input logic [9:0] a1, input logic [9:0] a2,
                        input logic [63:0] wd, input logic [63:0] e1, input logic [63:0] e2,
                        input int lat);
      @(negedge clk);
      mem_execute = 1'b1;
      mem_func    = f;
      address1    = a1;
      address2    = a2;
      write_data  = wd;
      sb.push_back('{e1, e2, cyc + lat});
      @(negedge clk);
      mem_execute = 1'b0;
      wait_done();
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_ready", 64'(mem_ready), 64'h0);
      chk("reset_rd1", read_data1, 64'h0);
      chk("reset_rd2", read_data2, 64'h0);
      chk("reset_error", 64'(error), 64'h0);
      chk("reset_free_addr", 64'(free_addr), 64'd512);

      // Preload cells, then allocate three.
      issue(F_SET, 10'd512, 10'd0, 64'hFF, 64'hFF, m_rd2, 2);
      issue(F_SET, 10'd20, 10'd0, 64'h55, 64'h55, m_rd2, 2);
      issue(F_FREE, 10'd0, 10'd0, 64'h0, 64'd512, m_rd2, FreeLat);
      issue(F_FREE, 10'd0, 10'd0, 64'h0, 64'd513, m_rd2, FreeLat);
      issue(F_FREE, 10'd0, 10'd0, 64'h0, 64'd514, m_rd2, FreeLat);
      chk("free_addr_after_3", 64'(free_addr), 64'd515);
      issue(F_GET, 10'd512, 10'd0, 64'h0, Exp512, m_rd2, 2);

      // Write then read back.
      issue(F_SET, 10'd5, 10'd0, 64'hA5, 64'hA5, m_rd2, 2);
      issue(F_GET, 10'd5, 10'd0, 64'h0, 64'hA5, m_rd2, 2);

      // Dual reads.
      issue(F_SET, 10'd7, 10'd0, 64'h11, 64'h11, m_rd2, 2);
      issue(F_SET, 10'd9, 10'd0, 64'h22, 64'h22, m_rd2, 2);
      m_rd2 = 64'h22;
      issue(F_PAIR, 10'd7, 10'd9, 64'h0, 64'h11, m_rd2, 2);
      m_rd2 = 64'h11;
      issue(F_PAIR, 10'd7, 10'd7, 64'h0, 64'h11, m_rd2, 2);

      // Null cell: write suppressed with flag, read returns zero.
      issue(F_SET, 10'd1023, 10'd0, 64'hDEAD, 64'hDEAD, m_rd2, 2);
      chk("error_nil_write", 64'(error), 64'h02);
      issue(F_GET, 10'd1023, 10'd0, 64'h0, 64'h0, m_rd2, 2);

      // Strobe held into ACCESS (as a GET_FREE) must be ignored.
      @(negedge clk);
      mem_execute = 1'b1;
      mem_func    = F_SET;
      address1    = 10'd30;
      write_data  = 64'h33;
      sb.push_back('{64'h33, m_rd2, cyc + 2});
      @(negedge clk);
      mem_func = F_FREE;
      @(negedge clk);
      mem_execute = 1'b0;
      wait_done();
      repeat (3) @(negedge clk);
      chk("ignored_strobe_free_addr", 64'(free_addr), 64'd515);
      issue(F_GET, 10'd30, 10'd0, 64'h0, 64'h33, m_rd2, 2);

      // Reset during ACCESS of a write: no response, write dropped.
      @(negedge clk);
      mem_execute = 1'b1;
      mem_func    = F_SET;
      address1    = 10'd20;
      write_data  = 64'h77;
      @(negedge clk);
      mem_execute = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      m_rd2 = 64'h0;
      chk("midreset_ready", 64'(mem_ready), 64'h0);
      chk("midreset_rd1", read_data1, 64'h0);
      chk("midreset_rd2", read_data2, 64'h0);
      chk("midreset_error", 64'(error), 64'h0);
      chk("midreset_free_addr", 64'(free_addr), 64'd512);
      issue(F_GET, 10'd20, 10'd0, 64'h0, 64'h55, m_rd2, 2);

      // Exhaust the allocator up to the null address.
      for (int i = 0; i < 511; i++) begin
         issue(F_FREE, 10'd0, 10'd0, 64'h0, 64'(512 + i), m_rd2, FreeLat);
      end
      chk("free_addr_at_nil", 64'(free_addr), 64'd1023);
      issue(F_FREE, 10'd0, 10'd0, 64'h0, 64'd1023, m_rd2, 2);
      chk("error_oom", 64'(error), 64'h01);
      chk("free_addr_stuck", 64'(free_addr), 64'd1023);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
